ipv4_field_sequencer: RTL
=========================

// Module: ipv4_field_sequencer
// PURPOSE
//  Programmable capture scheduler for IPv4 header fields on the avln_st stream.
//  - Taps the stream passively and starts on the IPv4 start pulse from the ethertype finder.
//  - Captures up to N_FIELDS 16-bit fields at configured word/bit positions.
//  - Hands captures to one downstream consumer (covert-channel detectors) over valid/ready.
//  - Replaces per-field extractor instances with one shared, sequenced datapath.
// PARAMETERS
//  N_FIELDS   4   number of capture slots (>=1)
//  MAX_WORD   15  last IPv4 word index examined; counter width = max($clog2(MAX_WORD+1),1)
//  CNT_W      16  width of the drop and miss counters
// PORTS
//  sys_clk     in   1               single clock, all logic on rising edge
//  reset_n     in   1               asynchronous, active-low reset
//  in          in   avln_st         monitored stream (valid/sop/eop/data); never back-pressured
//  start       in   1               IPv4 word 0 is on in.data this cycle
//  cfg         in   fld_cfg_t[N]    per slot: en, word_idx, offset (bits from MSB, <= W-16)
//  out_valid   out  1               a captured field is available
//  out_ready   in   1               consumer accepts when out_valid & out_ready
//  out_data    out  16              captured field
//  out_id      out  $clog2(N)|1     slot number of out_data
//  drop_cnt    out  CNT_W           captures lost to an occupied slot; saturates
//  miss_cnt    out  CNT_W           enabled slots not reached before packet end; saturates
// BEHAVIOUR
//  Reset: state=IDLE, word count 0, pending=0, hold regs 0, out_valid=0, out_data=0, out_id=0, counters=0.
//  FSM:
//   - IDLE -> SCAN on start & in.valid.
//   - SCAN -> IDLE on in.valid & (in.eop | count==MAX_WORD | all snapped slots done).
//   - start while in SCAN restarts at word 0.
//  Config snapshot: cfg is sampled into cfg_q on the start cycle. The start cycle itself matches against live cfg.
//  Word count: 0 on the start cycle (combinational override, as in count_words). Otherwise it advances by in.valid.
//  Match: slot k matches when SCAN (or start), in.valid, en_k, !done_k, and word_idx_k == count.
//   - Multiple slots may match the same word; all capture in parallel.
//   - On capture: hold_k <= in.data[W-1-offset_k -: 16]; pending_k <= 1; done_k <= 1.
//  Capture vs occupied slot:
//   - If pending_k=1 and slot k is not popped this cycle, the new capture is discarded and drop_cnt increments by 1.
//   - A drop on several slots in the same cycle adds the number of dropped slots.
//   - If slot k is popped and recaptured in the same cycle, the new data wins and pending_k stays 1 (no drop).
//  Output, combinational from registers:
//   - out_valid = |pending.
//   - out_id = lowest set pending bit.
//   - out_data = hold[out_id].
//   - Pop clears that pending bit. The next slot is presented the following cycle with no bubble.
//   - out_data/out_id are stable while out_valid & !out_ready.
//  Packet end or restart: every enabled, not-done slot adds 1 to miss_cnt. The done bits then clear.
//  Latency: field on in.data at cycle t appears on out_data at t+1 if it is the lowest pending slot.
//  Counters saturate at all-ones. Reset mid-packet drops all state immediately (async). No partial outputs survive.
// STRUCTURE
//  Additions to global_types:
//   - localparam IPV4_FIELD_W = 16.
//   - typedef struct packed {logic en; logic [7:0] word_idx; logic [$clog2(W)-1:0] offset;} fld_cfg_t.
//  One sub-module, lsb_pick #(N): pending vector -> {any, index of lowest set bit}, purely combinational.
//  FSM, match logic, hold/pending registers and counters stay in this module.
// TESTING (bench W=32, N_FIELDS=4, out_ready=1 unless stated)
//  1 slot0 {en,1,0}; packet word1=0x1234_4000
//    -> out_valid 1 cycle after word1; out_data=0x1234, out_id=0.
//  2 slot0 {1,0}, slot1 {1,16}, same word1=0xABCD_4000
//    -> 0xABCD id0, then 0x4000 id1 on the next cycle; no gap.
//  3 As test 2 with out_ready=0 for 5 cycles
//    -> out_data held at 0xABCD id0 for all 5 cycles; drains in order after release; drop_cnt=0.
//  4 Second packet's start before draining slot0
//    -> slot0 recapture dropped; drop_cnt=1; original value still delivered.
//  5 slot2 {en,word_idx=9}; eop at word 5
//    -> no output for slot2; miss_cnt=1; FSM back in IDLE after the eop cycle.
//  6 reset_n low mid-SCAN with 2 pending
//    -> out_valid=0 same cycle; counters=0; next packet captured normally.

Source files
------------

// File: rtl/ipv4_field_sequencer_pkg.sv
// Shared types for the IPv4 field sequencer: stream beat, per-slot capture config, FSM states.
package ipv4_field_sequencer_pkg;

  localparam int AVLN_DATA_W  = 32;
  localparam int IPV4_FIELD_W = 16;
  localparam int FLD_OFF_W    = $clog2(AVLN_DATA_W);

  typedef struct packed {
    logic                   valid;
    logic                   sop;
    logic                   eop;
    logic [AVLN_DATA_W-1:0] data;
  } avln_st_t;

  typedef struct packed {
    logic                 en;
    logic [7:0]           word_idx;
    logic [FLD_OFF_W-1:0] offset;
  } fld_cfg_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } seq_state_t;

  // offset counts bits from the MSB of the beat
  function automatic logic [IPV4_FIELD_W-1:0] extract_field(
    input logic [AVLN_DATA_W-1:0] data,
    input logic [FLD_OFF_W-1:0]   offset
  );
    logic [AVLN_DATA_W-1:0] shifted;
    shifted = data << offset;
    return shifted[AVLN_DATA_W-1 -: IPV4_FIELD_W];
  endfunction

endpackage

// File: rtl/ipv4_field_sequencer_lsb_pick.sv
// Lowest-set-bit picker: reports whether any bit is set and the index of the lowest one.
module ipv4_field_sequencer_lsb_pick #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ipv4_field_sequencer.sv
// Sequenced capture of up to N_FIELDS 16-bit IPv4 header fields, drained through one valid/ready port.
//  state | meaning
//  IDLE  | waiting for start on a valid beat
//  SCAN  | counting header words and capturing configured fields
module ipv4_field_sequencer
  import ipv4_field_sequencer_pkg::*;
#(
  parameter int N_FIELDS = 4,
  parameter int MAX_WORD = 15,
  parameter int CNT_W    = 16,
  localparam int ID_W    = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1,
  localparam int WC_W    = ($clog2(MAX_WORD + 1) > 1) ? $clog2(MAX_WORD + 1) : 1
) (
  input  logic                          sys_clk,
  input  logic                          reset_n,
  input  avln_st_t                      in,
  input  logic                          start,
  input  fld_cfg_t [N_FIELDS-1:0]       cfg,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IPV4_FIELD_W-1:0]       out_data,
  output logic [ID_W-1:0]               out_id,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [CNT_W-1:0]              miss_cnt
);

  seq_state_t              state_q, state_d;
  logic [WC_W-1:0]         count_q, count_d, count_eff;
  fld_cfg_t [N_FIELDS-1:0] cfg_q, cfg_eff;
  logic [N_FIELDS-1:0]     pending_q, pending_d, done_q, done_d, done_eff, done_after;
  logic [N_FIELDS-1:0]     en_eff, cap, drop, pop, miss_end, miss_restart;
  logic [IPV4_FIELD_W-1:0] hold_q [N_FIELDS];
  logic [CNT_W-1:0]        drop_cnt_q, miss_cnt_q;
  logic                    start_v, active, pkt_end, all_done;
  logic                    unused_sop;

  assign unused_sop = in.sop;

  function automatic int unsigned popcnt(input logic [N_FIELDS-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < N_FIELDS; i++) c += {31'd0, v[i]};
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  ipv4_field_sequencer_lsb_pick #(.N(N_FIELDS)) u_pick (
    .vec (pending_q),
    .any (out_valid),
    .idx (out_id)
  );

  assign out_data = hold_q[out_id];
  assign drop_cnt = drop_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // The start beat is word 0 and matches against live cfg; later beats use the snapshot.
  always_comb begin
    start_v   = start & in.valid;
    active    = (state_q == ST_SCAN) | start_v;
    count_eff = start_v ? '0 : count_q;
    cfg_eff   = start_v ? cfg : cfg_q;
    done_eff  = start_v ? '0 : done_q;
    for (int k = 0; k < N_FIELDS; k++) begin
      en_eff[k]       = cfg_eff[k].en;
      pop[k]          = out_valid & out_ready & (out_id == ID_W'(k));
      cap[k]          = active & in.valid & cfg_eff[k].en & ~done_eff[k]
                        & (32'(cfg_eff[k].word_idx) == 32'(count_eff));
      drop[k]         = cap[k] & pending_q[k] & ~pop[k];
      miss_restart[k] = (state_q == ST_SCAN) & start_v & cfg_q[k].en & ~done_q[k];
    end
    done_after = done_eff | cap;
    pending_d  = cap | (pending_q & ~pop);
    all_done   = &(done_after | ~en_eff);
    pkt_end    = active & in.valid & (in.eop | (count_eff == WC_W'(MAX_WORD)) | all_done);
    miss_end   = pkt_end ? (en_eff & ~done_after) : '0;

    state_d = ST_IDLE;
    count_d = '0;
    done_d  = '0;
    if (active && !pkt_end) begin
      state_d = ST_SCAN;
      count_d = in.valid ? count_eff + WC_W'(1) : count_eff;
      done_d  = done_after;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      cfg_q      <= '0;
      done_q     <= '0;
      pending_q  <= '0;
      drop_cnt_q <= '0;
      miss_cnt_q <= '0;
      for (int k = 0; k < N_FIELDS; k++) hold_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      pending_q <= pending_d;
      if (start_v) cfg_q <= cfg;
      for (int k = 0; k < N_FIELDS; k++) begin
        if (cap[k] && !drop[k]) hold_q[k] <= extract_field(in.data, cfg_eff[k].offset);
      end
      drop_cnt_q <= sat_add(drop_cnt_q, popcnt(drop));
      miss_cnt_q <= sat_add(miss_cnt_q, popcnt(miss_end) + popcnt(miss_restart));
    end
  end

endmodule
